// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes and master FSM state encoding
package axil_pkg;

    localparam logic [1:0] AXIL_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_EXOKAY = 2'b01;
    localparam logic [1:0] AXIL_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_RSP  = 3'd5
    } axil_master_state_t;

endpackage

// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding AXI4-Lite initiator behind a command/response port
module axil_master
    import axil_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 16,
    parameter int         STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam int OFF_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;

    axil_master_state_t    state;
    logic                  ready_en;
    logic                  aw_done;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            resp_q;

    logic misaligned;
    logic aw_hs;
    logic w_hs;

    assign misaligned = (STRB_WIDTH > 1) && (cmd_addr[OFF_W-1:0] != '0);

    // ready_en keeps cmd_ready low while reset is held, even though state already reads IDLE
    assign cmd_ready      = (state == ST_IDLE) && ready_en;
    assign rsp_valid      = (state == ST_RSP);
    assign rsp_rdata      = rdata_q;
    assign rsp_resp       = resp_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = PROT;
    assign m_axil_awvalid = (state == ST_WR) && !aw_done;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = (state == ST_WR) && !w_done;
    assign m_axil_bready  = (state == ST_WB);
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = PROT;
    assign m_axil_arvalid = (state == ST_RA);
    assign m_axil_rready  = (state == ST_RD);

    assign aw_hs = m_axil_awvalid && m_axil_awready;
    assign w_hs  = m_axil_wvalid && m_axil_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ready_en <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            resp_q   <= AXIL_OKAY;
        end else begin
            ready_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (misaligned) begin
                            rdata_q <= '0;
                            resp_q  <= AXIL_SLVERR;
                            state   <= ST_RSP;
                        end else if (cmd_we) begin
                            state   <= ST_WR;
                        end else begin
                            state   <= ST_RA;
                        end
                    end
                end
                ST_WR: begin
                    // AW and W complete independently; move on once both have been taken
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_WB;
                end
                ST_WB: begin
                    if (m_axil_bvalid) begin
                        rdata_q <= '0;
                        resp_q  <= m_axil_bresp;
                        state   <= ST_RSP;
                    end
                end
                ST_RA: begin
                    if (m_axil_arready) state <= ST_RD;
                end
                ST_RD: begin
                    if (m_axil_rvalid) begin
                        rdata_q <= m_axil_rdata;
                        resp_q  <= m_axil_rresp;
                        state   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
